// File: rtl/fixed_pkg.sv
// Shared constants and engine state type for the fixed-point divide / square-root block.
// Formats are signed 24.8 by default.
package fixed_pkg;

    localparam int WIDTH        = 32;
    localparam int FRAC         = 8;
    localparam int SQRT_LATENCY = 21;
    localparam int DIV_LATENCY  = 41;

    localparam logic [WIDTH-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [WIDTH-1:0] SAT_NEG = 32'h8000_0001;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } eng_state_t;

endpackage

// File: rtl/fx_divider.sv
// Signed fixed-point divider: restoring division on magnitudes, one quotient bit per
// cycle, followed by a single sign/saturation cycle that drives the result.
module fx_divider #(
    parameter int WIDTH = fixed_pkg::WIDTH,
    parameter int FRAC  = fixed_pkg::FRAC
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo,
    output logic             done
);
    import fixed_pkg::*;

    localparam int EXT = WIDTH + FRAC;
    localparam int CW  = $clog2(EXT + 1);

    eng_state_t       state_q;
    logic [CW-1:0]    cnt_q;
    logic [EXT-1:0]   quo_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] den_q;
    logic             neg_q;
    logic             a_neg_q;
    logic             zero_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic             ovf;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] fin;

    // Negating the most negative value wraps back to itself, which is still the
    // correct unsigned magnitude.
    assign a_mag  = a[WIDTH-1] ? -a : a;
    assign rem_sh = {rem_q[WIDTH-1:0], quo_q[EXT-1]};
    assign ge     = rem_sh >= {1'b0, den_q};
    assign ovf    = |quo_q[EXT-1:WIDTH-1];
    assign mag    = quo_q[WIDTH-1:0];

    always_comb begin
        fin = neg_q ? -mag : mag;
        if (zero_q)
            fin = a_neg_q ? WIDTH'(SAT_NEG) : WIDTH'(SAT_POS);
        else if (ovf)
            fin = neg_q ? WIDTH'(SAT_NEG) : WIDTH'(SAT_POS);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            quo     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // A start always wins: an in-flight division is simply dropped.
                state_q <= BUSY;
                cnt_q   <= '0;
                quo_q   <= {a_mag, {FRAC{1'b0}}};
                rem_q   <= '0;
                den_q   <= b[WIDTH-1] ? -b : b;
                neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                a_neg_q <= a[WIDTH-1];
                zero_q  <= (b == '0);
            end else if (state_q == BUSY) begin
                if (cnt_q == CW'(EXT)) begin
                    state_q <= IDLE;
                    quo     <= fin;
                    done    <= 1'b1;
                end else begin
                    quo_q <= {quo_q[EXT-2:0], ge};
                    rem_q <= ge ? rem_sh - {1'b0, den_q} : rem_sh;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fixed_div_sqrt.sv
// Independent fixed-point square-root (inline, one root bit per cycle) and divide
// (fx_divider) engines sharing a clock and reset.
module fixed_div_sqrt #(
    parameter int WIDTH = fixed_pkg::WIDTH,
    parameter int FRAC  = fixed_pkg::FRAC
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             sqrt_start,
    input  logic [WIDTH-1:0] sqrt_rad,
    output logic [WIDTH-1:0] sqrt_root,
    output logic             sqrt_valid,
    input  logic             div_start,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    output logic [WIDTH-1:0] div_val,
    output logic             div_done
);
    import fixed_pkg::*;

    localparam int EXT   = WIDTH + FRAC;
    localparam int ITERS = EXT / 2;
    localparam int RW    = ITERS + 4;
    localparam int CW    = $clog2(ITERS + 1);

    eng_state_t       sq_state_q;
    logic [CW-1:0]    sq_cnt_q;
    logic [EXT-1:0]   sq_rad_q;
    logic [RW-1:0]    sq_rem_q;
    logic [ITERS-1:0] sq_root_q;

    logic [RW-1:0]    sq_rem_sh;
    logic [RW-1:0]    sq_trial;
    logic             sq_ge;

    // Digit-by-digit root: bring down two radicand bits, try (root<<2)|1.
    assign sq_rem_sh = {sq_rem_q[RW-3:0], sq_rad_q[EXT-1 -: 2]};
    assign sq_trial  = RW'({sq_root_q, 2'b01});
    assign sq_ge     = sq_rem_sh >= sq_trial;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sq_state_q <= IDLE;
            sq_cnt_q   <= '0;
            sq_rad_q   <= '0;
            sq_rem_q   <= '0;
            sq_root_q  <= '0;
            sqrt_root  <= '0;
            sqrt_valid <= 1'b0;
        end else begin
            sqrt_valid <= 1'b0;
            if (sqrt_start) begin
                sq_state_q <= BUSY;
                sq_cnt_q   <= '0;
                // A negative radicand runs as zero so the latency stays fixed.
                sq_rad_q   <= sqrt_rad[WIDTH-1] ? '0 : {sqrt_rad, {FRAC{1'b0}}};
                sq_rem_q   <= '0;
                sq_root_q  <= '0;
            end else if (sq_state_q == BUSY) begin
                if (sq_cnt_q == CW'(ITERS)) begin
                    sq_state_q <= IDLE;
                    sqrt_root  <= WIDTH'(sq_root_q);
                    sqrt_valid <= 1'b1;
                end else begin
                    sq_rad_q  <= {sq_rad_q[EXT-3:0], 2'b00};
                    sq_rem_q  <= sq_ge ? sq_rem_sh - sq_trial : sq_rem_sh;
                    sq_root_q <= {sq_root_q[ITERS-2:0], sq_ge};
                    sq_cnt_q  <= sq_cnt_q + 1'b1;
                end
            end
        end
    end

    fx_divider #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_div (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start    (div_start),
        .a        (div_a),
        .b        (div_b),
        .quo      (div_val),
        .done     (div_done)
    );

endmodule

// File: tb/tb_fixed_div_sqrt.sv
// Bench for fixed_div_sqrt: vector table, concurrency/restart/reset sequences and
// randomized operands against an arithmetic reference model.
module tb_fixed_div_sqrt;

    localparam int SQ_LAT  = 21;
    localparam int DIV_LAT = 41;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        sqrt_start = 1'b0;
    logic [31:0] sqrt_rad = '0;
    logic [31:0] sqrt_root;
    logic        sqrt_valid;
    logic        div_start = 1'b0;
    logic [31:0] div_a = '0;
    logic [31:0] div_b = '0;
    logic [31:0] div_val;
    logic        div_done;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    fixed_div_sqrt #(.WIDTH(32), .FRAC(8)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .sqrt_start (sqrt_start),
        .sqrt_rad   (sqrt_rad),
        .sqrt_root  (sqrt_root),
        .sqrt_valid (sqrt_valid),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_val    (div_val),
        .div_done   (div_done)
    );

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Reference: floor(sqrt(rad * 256)), zero for negative radicands.
    function automatic logic [31:0] m_sqrt(input logic [31:0] rad);
        longint x, r;
        if (rad[31]) return 32'h0;
        x = longint'(rad) * 256;
        r = longint'($sqrt(real'(x)));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return 32'(r);
    endfunction

    // Reference: (a * 256) / b truncated toward zero, saturated to +/-0x7FFFFFFF.
    function automatic logic [31:0] m_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0001;
        q = (sa * 256) / sb;
        if (q > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (q < -64'sd2147483647) return 32'h8000_0001;
        return 32'(q);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic add(input bit d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input string nm);
        vec_t v;
        v.is_div = d; v.a = a; v.b = b; v.exp = e; v.name = nm;
        vecs.push_back(v);
    endtask

    // Presents operands so the next rising edge is edge 0, then scrambles them.
    task automatic start_ops(input logic s, input logic [31:0] rad,
                             input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_in);
        sqrt_start = s; sqrt_rad = rad;
        div_start  = d; div_a = a; div_b = b;
        @(posedge clk_in);
        #1;
        sqrt_start = 1'b0; div_start = 1'b0;
        sqrt_rad = $urandom; div_a = $urandom; div_b = $urandom;
    endtask

    // Observes edges 1..n; optionally restarts div at rs_edge or pulls reset low at rst_edge.
    task automatic watch(input int n, input int rs_edge, input logic [31:0] ra,
                         input logic [31:0] rb, input int rst_edge,
                         output int s_n, output int s_e, output int d_n, output int d_e,
                         output logic [31:0] s_v, output logic [31:0] d_v);
        s_n = 0; s_e = -1; d_n = 0; d_e = -1; s_v = '0; d_v = '0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk_in);
            #1;
            div_start = 1'b0;
            if (sqrt_valid) begin s_n++; s_e = k; s_v = sqrt_root; end
            if (div_done)   begin d_n++; d_e = k; d_v = div_val;   end
            if (k == rs_edge - 1) begin
                div_start = 1'b1; div_a = ra; div_b = rb;
            end
            if (k == rst_edge - 1) begin
                rst_n_in = 1'b0;
                #1;
                chk("rst_async/div_val",    div_val,    32'h0);
                chk("rst_async/div_done",   {31'h0, div_done}, 32'h0);
                chk("rst_async/sqrt_root",  sqrt_root,  32'h0);
                chk("rst_async/sqrt_valid", {31'h0, sqrt_valid}, 32'h0);
            end
            if (k == rst_edge + 1) rst_n_in = 1'b1;
        end
    endtask

    initial begin
        int s_n, s_e, d_n, d_e;
        logic [31:0] s_v, d_v, ra, rb, rr;

        repeat (2) @(posedge clk_in);
        #1;
        chk("reset/sqrt_root",  sqrt_root, 32'h0);
        chk("reset/sqrt_valid", {31'h0, sqrt_valid}, 32'h0);
        chk("reset/div_val",    div_val, 32'h0);
        chk("reset/div_done",   {31'h0, div_done}, 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        add(0, 32'h0000_0400, 0, 32'h0000_0200, "sqrt_4");
        add(0, 32'h0000_0200, 0, 32'h0000_016A, "sqrt_2");
        add(0, 32'hFFFF_FF00, 0, 32'h0000_0000, "sqrt_neg");
        add(0, 32'h0000_0000, 0, 32'h0000_0000, "sqrt_0");
        add(0, 32'h0000_0100, 0, 32'h0000_0100, "sqrt_1");
        add(0, 32'h0001_0000, 0, 32'h0000_1000, "sqrt_256");
        add(1, 32'h0000_0300, 32'h0000_0200, 32'h0000_0180, "div_3_2");
        add(1, 32'hFFFF_FD00, 32'h0000_0200, 32'hFFFF_FE80, "div_m3_2");
        add(1, 32'h0000_0100, 32'h0000_0000, 32'h7FFF_FFFF, "div_pos_by0");
        add(1, 32'hFFFF_FF00, 32'h0000_0000, 32'h8000_0001, "div_neg_by0");
        add(1, 32'h0000_0100, 32'hFFFF_FF00, 32'hFFFF_FF00, "div_1_m1");
        add(1, 32'h7FFF_FFFF, 32'h0000_0080, 32'h7FFF_FFFF, "div_ovf_pos");
        add(1, 32'h8000_0000, 32'h0000_0080, 32'h8000_0001, "div_ovf_neg");
        add(1, 32'h0000_0100, 32'h0000_0300, 32'h0000_0055, "div_1_3");
        add(1, 32'hFFFF_FF00, 32'h0000_0300, 32'hFFFF_FFAB, "div_m1_3");

        foreach (vecs[i]) begin
            if (vecs[i].is_div) start_ops(0, 32'h0, 1, vecs[i].a, vecs[i].b);
            else                start_ops(1, vecs[i].a, 0, 32'h0, 32'h0);
            watch(45, -1, 0, 0, -1, s_n, s_e, d_n, d_e, s_v, d_v);
            if (vecs[i].is_div) begin
                chk({vecs[i].name, "/pulses"}, d_n, 1);
                chk({vecs[i].name, "/edge"},   d_e, DIV_LAT);
                chk({vecs[i].name, "/value"},  d_v, vecs[i].exp);
                chk({vecs[i].name, "/hold"},   div_val, vecs[i].exp);
            end else begin
                chk({vecs[i].name, "/pulses"}, s_n, 1);
                chk({vecs[i].name, "/edge"},   s_e, SQ_LAT);
                chk({vecs[i].name, "/value"},  s_v, vecs[i].exp);
                chk({vecs[i].name, "/hold"},   sqrt_root, vecs[i].exp);
            end
        end

        // Both engines together; operands are scrambled right after the start edge.
        start_ops(1, 32'h0001_9000, 1, 32'h0000_0A00, 32'h0000_0400);
        watch(45, -1, 0, 0, -1, s_n, s_e, d_n, d_e, s_v, d_v);
        chk("conc/sqrt_pulses", s_n, 1);
        chk("conc/sqrt_edge",   s_e, SQ_LAT);
        chk("conc/sqrt_value",  s_v, 32'h0000_1400);
        chk("conc/div_pulses",  d_n, 1);
        chk("conc/div_edge",    d_e, DIV_LAT);
        chk("conc/div_value",   d_v, 32'h0000_0280);

        for (int t = 0; t < 20; t++) begin
            rr = $urandom >> $urandom_range(0, 24);
            if ($urandom_range(0, 3) == 0) rr = -rr;
            ra = $urandom >> $urandom_range(0, 24);
            rb = $urandom >> $urandom_range(4, 28);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            start_ops(1, rr, 1, ra, rb);
            watch(45, -1, 0, 0, -1, s_n, s_e, d_n, d_e, s_v, d_v);
            chk("rand/sqrt_pulses", s_n, 1);
            chk("rand/sqrt_edge",   s_e, SQ_LAT);
            chk("rand/sqrt_value",  s_v, m_sqrt(rr));
            chk("rand/div_pulses",  d_n, 1);
            chk("rand/div_edge",    d_e, DIV_LAT);
            chk("rand/div_value",   d_v, m_div(ra, rb));
        end

        // Restart at edge 10: only the second division may complete, at edge 51.
        start_ops(0, 32'h0, 1, 32'h0000_0900, 32'h0000_0300);
        watch(60, 10, 32'h0000_0700, 32'hFFFF_FE00, -1, s_n, s_e, d_n, d_e, s_v, d_v);
        chk("restart/pulses", d_n, 1);
        chk("restart/edge",   d_e, 10 + DIV_LAT);
        chk("restart/value",  d_v, 32'hFFFF_FC80);

        // Reset at edge 15 of a divide: no completion, then a fresh divide works.
        start_ops(0, 32'h0, 1, 32'h0000_0500, 32'h0000_0200);
        watch(50, -1, 0, 0, 15, s_n, s_e, d_n, d_e, s_v, d_v);
        chk("rstmid/div_pulses",  d_n, 0);
        chk("rstmid/sqrt_pulses", s_n, 0);
        start_ops(0, 32'h0, 1, 32'h0000_0500, 32'h0000_0200);
        watch(45, -1, 0, 0, -1, s_n, s_e, d_n, d_e, s_v, d_v);
        chk("after_rst/pulses", d_n, 1);
        chk("after_rst/edge",   d_e, DIV_LAT);
        chk("after_rst/value",  d_v, 32'h0000_0280);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
